// File: rtl/mem_wb_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wb_skid_reg                                                              |
// | Two-entry MEM/WB skid register with misalign transform and thread flushes. |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module mem_wb_skid_reg #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int TID_W          = 2,
  parameter int EXP_W          = 3,
  parameter int EXP_MISS_ALIGN = 1,
  parameter int THREADS        = 2**TID_W
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [TID_W-1:0]    ex_tid,
  input  logic [ADDR_W-1:0]   ex_dst_addr,
  input  logic                ex_gpr_we_,
  input  logic [EXP_W-1:0]    ex_exp_code,
  input  logic [DATA_W-1:0]   out,
  input  logic                miss_align,
  input  logic                stall,
  input  logic                flush,
  input  logic [THREADS-1:0]  flush_tid,
  output logic                mem_valid,
  input  logic                wb_ready,
  output logic [TID_W-1:0]    mem_tid,
  output logic [ADDR_W-1:0]   mem_dst_addr,
  output logic                mem_gpr_we_,
  output logic [EXP_W-1:0]    mem_exp_code,
  output logic [DATA_W-1:0]   mem_out,
  output logic [1:0]          mem_occ
);

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [ADDR_W-1:0] dst;
    logic              we_;
    logic [EXP_W-1:0]  exp;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam entry_t c_ENTRY_RST = '{tid: '0, dst: '0, we_: 1'b1, exp: '0, data: '0};

  logic   r_m_valid, r_s_valid;
  entry_t r_m, r_s;
  entry_t w_in;
  logic   w_take, w_m_live, w_s_live, w_s_kill, w_m_free;

  // Misaligned accesses are turned into a non-writing exception bubble.
  always_comb begin
    w_in      = '{tid: ex_tid, dst: ex_dst_addr, we_: ex_gpr_we_, exp: ex_exp_code, data: out};
    if (miss_align) begin
      w_in.dst  = '0;
      w_in.we_  = 1'b1;
      w_in.data = '0;
      w_in.exp  = (ex_exp_code != '0) ? ex_exp_code : EXP_W'(EXP_MISS_ALIGN);
    end
  end

  assign ex_ready = ~r_s_valid;
  assign w_take   = ex_valid & ex_ready & ~flush_tid[ex_tid];
  assign w_m_live = r_m_valid & ~flush_tid[r_m.tid];
  assign w_s_kill = r_s_valid &  flush_tid[r_s.tid];
  assign w_s_live = r_s_valid & ~flush_tid[r_s.tid];
  // A killed M counts as empty so a surviving S can advance even under stall.
  assign w_m_free = ~w_m_live | (wb_ready & ~stall);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= c_ENTRY_RST;
      r_s       <= c_ENTRY_RST;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= c_ENTRY_RST;
      r_s       <= c_ENTRY_RST;
    end else if (w_m_free) begin
      if (w_s_live) begin
        r_m       <= r_s;
        r_m_valid <= 1'b1;
      end else if (w_take) begin
        r_m       <= w_in;
        r_m_valid <= 1'b1;
      end else begin
        r_m_valid <= 1'b0;
      end
      r_s_valid <= 1'b0;
    end else begin
      if (w_take) begin
        r_s       <= w_in;
        r_s_valid <= 1'b1;
      end else if (w_s_kill) begin
        r_s_valid <= 1'b0;
      end
    end
  end

  assign mem_valid    = r_m_valid;
  assign mem_tid      = r_m.tid;
  assign mem_dst_addr = r_m.dst;
  assign mem_gpr_we_  = r_m.we_;
  assign mem_exp_code = r_m.exp;
  assign mem_out      = r_m.data;
  assign mem_occ      = {1'b0, r_m_valid} + {1'b0, r_s_valid};

endmodule
`default_nettype wire
